capture_ctrl: RTL and testbench



---
 rtl/osc_pkg.sv | 13 +
 rtl/capture_ctrl_if.sv | 21 ++
 rtl/sync_edge.sv | 26 ++
 rtl/capture_ctrl.sv | 115 +++++++++++
 tb/tb_capture_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/osc_pkg.sv
// Shared definitions for the scope capture path (capture sequencer, sample RAM, Pi link).
package osc_pkg;

    localparam int SAMPLE_W  = 8;
    localparam int BUF_DEPTH = 1024;

    typedef enum logic [1:0] {
        WAIT_TRIG = 2'd0,
        FILL      = 2'd1,
        FULL      = 2'd2
    } cap_state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Sample stream in, RAM write port out. The master side is the capture sequencer.
interface capture_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADR_W  = 10
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              write_en;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] write_data;

    modport master (
        input  sample_valid, sample_data,
        output write_en, adr, write_data
    );

    modport slave (
        output sample_valid, sample_data,
        input  write_en, adr, write_data
    );
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic osc_clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: waits for a trigger, writes DEPTH samples from address 0,
// then holds pi_signal_flag until the Pi reports the buffer has been read.
module capture_ctrl
    import osc_pkg::*;
#(
    parameter int DEPTH       = BUF_DEPTH,
    parameter int ADR_W       = 10,
    parameter int DATA_W      = SAMPLE_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic              osc_clk,
    input  logic              reset_n,
    capture_ctrl_if.master    bus,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              pi_done,
    output logic              pi_signal_flag,
    output logic              triggered,
    output logic              auto_trig
);

    localparam logic [1:0] ST_WAIT = WAIT_TRIG;
    localparam logic [1:0] ST_FILL = FILL;
    localparam logic [1:0] ST_FULL = FULL;

    localparam int              TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADR_W-1:0]  wr_ptr;
    logic              prev_valid;
    logic [DATA_W-1:0] prev_sample;
    logic [TO_W-1:0]   to_cnt;
    logic              done_rise;
    logic              lvl_hit, cond_main, to_hit, fire;

    sync_edge #(.STAGES(SYNC_STAGES)) u_done_sync (
        .osc_clk (osc_clk),
        .reset_n (reset_n),
        .d       (pi_done),
        .rise    (done_rise)
    );

    always_comb begin
        lvl_hit   = prev_valid && (prev_sample < trig_level) && (bus.sample_data >= trig_level);
        cond_main = !trig_en || lvl_hit;
        to_hit    = (TIMEOUT != 0) && (to_cnt == TO_MAX);
        fire      = cond_main || to_hit;
    end

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_WAIT;
            wr_ptr         <= '0;
            prev_valid     <= 1'b0;
            prev_sample    <= '0;
            to_cnt         <= '0;
            bus.write_en   <= 1'b0;
            bus.adr        <= '0;
            bus.write_data <= '0;
            pi_signal_flag <= 1'b0;
            triggered      <= 1'b0;
            auto_trig      <= 1'b0;
        end else begin
            bus.write_en <= 1'b0;
            triggered    <= 1'b0;
            case (state)
                ST_WAIT: begin
                    if (bus.sample_valid) begin
                        if (fire) begin
                            bus.write_en   <= 1'b1;
                            bus.adr        <= '0;
                            bus.write_data <= bus.sample_data;
                            triggered      <= 1'b1;
                            auto_trig      <= to_hit && !cond_main;
                            wr_ptr         <= ADR_W'(1);
                            state          <= ST_FILL;
                        end else begin
                            prev_sample <= bus.sample_data;
                            prev_valid  <= 1'b1;
                            if (to_cnt != TO_MAX)
                                to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (bus.sample_valid) begin
                        bus.write_en   <= 1'b1;
                        bus.adr        <= wr_ptr;
                        bus.write_data <= bus.sample_data;
                        wr_ptr         <= wr_ptr + 1'b1;
                        if (wr_ptr == LAST_ADR)
                            state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // A sample arriving alongside the release is dropped, not evaluated.
                    if (done_rise) begin
                        pi_signal_flag <= 1'b0;
                        state          <= ST_WAIT;
                        wr_ptr         <= '0;
                        prev_valid     <= 1'b0;
                        to_cnt         <= '0;
                    end else begin
                        pi_signal_flag <= 1'b1;
                    end
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl; RAM writes are checked against a queue of expected writes.
module tb_capture_ctrl;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int SS    = 2;
    localparam int TO    = 16;

    logic          osc_clk = 1'b0;
    logic          reset_n;
    logic          trig_en;
    logic [DW-1:0] trig_level;
    logic          pi_done;
    logic          pi_signal_flag, triggered, auto_trig;

    int n_vec = 0;
    int n_err = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_e;

    capture_ctrl_if #(.DATA_W(DW), .ADR_W(AW)) bus ();

    capture_ctrl #(
        .DEPTH(DEPTH), .ADR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT(TO)
    ) dut (
        .osc_clk        (osc_clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .trig_en        (trig_en),
        .trig_level     (trig_level),
        .pi_done        (pi_done),
        .pi_signal_flag (pi_signal_flag),
        .triggered      (triggered),
        .auto_trig      (auto_trig)
    );

    always #5 osc_clk = ~osc_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; drives one strobe that the DUT samples on the next edge.
    task automatic send(input logic [DW-1:0] d, input bit wr, input int a);
        if (wr) exp_q.push_back({AW'(a), d});
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        @(posedge osc_clk);
        #1;
        bus.sample_valid = 1'b0;
    endtask

    always @(negedge osc_clk) begin
        if (bus.write_en === 1'b1) begin
            n_vec++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_write: got adr=%0d data=%0h, expected no write", bus.adr, bus.write_data);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_vec++;
                assert ({bus.adr, bus.write_data} === mon_e) else begin
                    n_err++;
                    $error("FAIL write_adr_data: got adr=%0d data=%0h, expected adr=%0d data=%0h",
                           bus.adr, bus.write_data, mon_e[AW+DW-1:DW], mon_e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        reset_n    = 1'b0;
        pi_done    = 1'b0;
        trig_en    = 1'b0;
        trig_level = '0;
        #12;
        chk("rst_write_en",   bus.write_en,   0);
        chk("rst_adr",        bus.adr,        0);
        chk("rst_write_data", bus.write_data, 0);
        chk("rst_flag",       pi_signal_flag, 0);
        chk("rst_triggered",  triggered,      0);
        chk("rst_auto_trig",  auto_trig,      0);
        @(negedge osc_clk) reset_n = 1'b1;
        @(posedge osc_clk);
        #1;

        // Capture 1: free-running trigger, data = index mod 256
        for (int i = 0; i < DEPTH; i++) begin
            send(DW'(i), 1'b1, i);
            if (i == 0) begin
                chk("cap1_triggered", triggered, 1);
                chk("cap1_auto_trig", auto_trig, 0);
            end
            if (i == 1) chk("cap1_trig_pulse", triggered, 0);
        end
        chk("cap1_flag_at_last_write", pi_signal_flag, 0);
        @(posedge osc_clk);
        #1;
        chk("cap1_flag_after_last", pi_signal_flag, 1);
        send(8'h55, 1'b0, 0);
        chk("full_no_write", bus.write_en, 0);
        chk("full_flag_held", pi_signal_flag, 1);

        // Release: flag drops in the (SS+2)-th cycle counting the cycle pi_done rose in
        #2 pi_done = 1'b1;
        repeat (SS) @(posedge osc_clk);
        #1;
        chk("release_flag_not_yet", pi_signal_flag, 1);
        @(posedge osc_clk);
        #1;
        chk("release_flag_low", pi_signal_flag, 0);

        // Capture 2: level trigger on rising crossing of 0x80
        trig_en    = 1'b1;
        trig_level = 8'h80;
        send(8'h70, 1'b0, 0);
        send(8'h78, 1'b0, 0);
        send(8'h7F, 1'b0, 0);
        chk("lvl_no_trig_below", triggered, 0);
        send(8'h80, 1'b1, 0);
        chk("lvl_triggered", triggered, 1);
        chk("lvl_auto_trig", auto_trig, 0);
        send(8'h81, 1'b1, 1);
        for (int i = 2; i < DEPTH; i++) send(DW'(i * 7), 1'b1, i);
        @(posedge osc_clk);
        #1;
        chk("cap2_flag", pi_signal_flag, 1);
        repeat (10) @(posedge osc_clk);
        #1;
        chk("held_done_no_release", pi_signal_flag, 1);
        pi_done = 1'b0;
        repeat (4) @(posedge osc_clk);
        #1;
        chk("done_fall_no_release", pi_signal_flag, 1);

        // New rising edge; a strobe lands in the same cycle as done_rise and must be dropped
        #2 pi_done = 1'b1;
        repeat (SS) @(posedge osc_clk);
        #1;
        send(8'h10, 1'b0, 0);
        chk("coinc_flag_low", pi_signal_flag, 0);
        chk("coinc_no_trig", triggered, 0);
        send(8'h90, 1'b0, 0);
        chk("rearm_seed_only", triggered, 0);
        send(8'h70, 1'b0, 0);
        send(8'h85, 1'b1, 0);
        chk("cap3_triggered", triggered, 1);
        for (int i = 1; i < 500; i++) send(DW'(i + 3), 1'b1, i);

        // Abort mid-fill with wr_ptr at 500
        @(negedge osc_clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_write_en",   bus.write_en,   0);
        chk("abort_adr",        bus.adr,        0);
        chk("abort_write_data", bus.write_data, 0);
        chk("abort_flag",       pi_signal_flag, 0);
        chk("abort_triggered",  triggered,      0);
        chk("abort_q_drained",  exp_q.size(),   0);
        #10 reset_n = 1'b1;
        @(posedge osc_clk);
        #1;

        // Timeout: constant 0x90 never crosses the level; 16th strobe forces the trigger
        for (int k = 1; k < TO; k++) send(8'h90, 1'b0, 0);
        chk("to_not_before", triggered, 0);
        send(8'h90, 1'b1, 0);
        chk("to_triggered", triggered, 1);
        chk("to_auto_trig", auto_trig, 1);
        send(8'h91, 1'b1, 1);
        chk("to_auto_sticky", auto_trig, 1);
        @(posedge osc_clk);
        #1;
        chk("end_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
